// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage RV core: hold/flush control for PC, IF/ID and ID/EX.
// Optional build macro PIPE_CTRL_PERF_EN adds stall/flush performance counters.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_ren_i,
    input  logic        id_rs2_ren_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_is_load_i,
    input  logic        ex_jump_en_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
`endif
    output logic        fault_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(MEM_TIMEOUT);

    state_t          state_r;
    logic [TO_W-1:0] cnt_r;
    logic            fault_r;

    logic hazard_s;
    logic memstall_s;
    logic eval_run_s;

    assign hazard_s = ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
                      ((id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i)));
    assign memstall_s = mem_req_i && !mem_ack_i;
    // Jump/hazard rules apply in RUN without a stall, and on the ack cycle that releases MEM_WAIT.
    assign eval_run_s = ((state_r == RUN) && !memstall_s) ||
                        ((state_r == MEM_WAIT) && mem_ack_i);

    // Zero-latency control outputs decoded from state and current inputs.
    always_comb begin
        jump_en_o     = 1'b0;
        jump_addr_o   = 32'h0000_0000;
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        hold_id_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        fault_o       = 1'b0;
        if (!rst) begin
            fault_o = 1'b0;
        end else if (eval_run_s) begin
            if (ex_jump_en_i) begin
                jump_en_o     = 1'b1;
                jump_addr_o   = ex_jump_addr_i;
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
            end else if (hazard_s) begin
                hold_pc_o     = 1'b1;
                hold_if_id_o  = 1'b1;
                flush_id_ex_o = 1'b1;
            end else begin
                hold_pc_o     = 1'b0;
            end
        end else begin
            // Memory stall, ongoing wait, fault, or an illegal state: freeze the whole pipe.
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
            fault_o      = fault_r;
        end
    end

    // Sequencer state, wait-timeout counter and sticky fault flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= RUN;
            cnt_r   <= '0;
            fault_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (memstall_s) begin
                        state_r <= MEM_WAIT;
                        cnt_r   <= TO_W'(1);
                    end else begin
                        state_r <= RUN;
                        cnt_r   <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack_i) begin
                        state_r <= RUN;
                        cnt_r   <= '0;
                    end else if (cnt_r == TIMEOUT_C) begin
                        state_r <= FAULT;
                        fault_r <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + TO_W'(1);
                    end
                end
                FAULT: begin
                    state_r <= FAULT;
                    fault_r <= 1'b1;
                end
                default: begin
                    state_r <= FAULT;
                    fault_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Free-running performance counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_o <= 32'd0;
            flush_cnt_o <= 32'd0;
        end else begin
            if (hold_pc_o) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end else begin
                stall_cnt_o <= stall_cnt_o;
            end
            if (flush_if_id_o) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end else begin
                flush_cnt_o <= flush_cnt_o;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; DUT built with MEM_TIMEOUT=4.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_rs1_ren, id_rs2_ren, ex_is_load, ex_jump_en;
    logic [31:0] ex_jump_addr;
    logic        mem_req, mem_ack;
    logic        jump_en, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, fault;
    logic [31:0] jump_addr;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif
    logic [6:0]  obs;

    int checks = 0;
    int errors = 0;

    // obs = {jump_en, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, fault}
    localparam logic [6:0] O_IDLE   = 7'b000_0000;
    localparam logic [6:0] O_BUBBLE = 7'b011_0010;
    localparam logic [6:0] O_JUMP   = 7'b100_0110;
    localparam logic [6:0] O_HOLD   = 7'b011_1000;
    localparam logic [6:0] O_FAULT  = 7'b011_1001;

    assign obs = {jump_en, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, fault};

    pipe_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
        .id_rs1_ren_i(id_rs1_ren), .id_rs2_ren_i(id_rs2_ren),
        .ex_rd_addr_i(ex_rd_addr), .ex_is_load_i(ex_is_load),
        .ex_jump_en_i(ex_jump_en), .ex_jump_addr_i(ex_jump_addr),
        .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .jump_en_o(jump_en), .jump_addr_o(jump_addr),
        .hold_pc_o(hold_pc), .hold_if_id_o(hold_if_id), .hold_id_ex_o(hold_id_ex),
        .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
`endif
        .fault_o(fault)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        id_rs1_ren = 1'b0; id_rs2_ren = 1'b0; ex_is_load = 1'b0;
        ex_jump_en = 1'b0; ex_jump_addr = 32'h0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic set_hazard();
        ex_is_load = 1'b1; ex_rd_addr = 5'd5; id_rs1_ren = 1'b1; id_rs1_addr = 5'd5;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; idle_inputs();
        ex_jump_en = 1'b1; ex_jump_addr = 32'h1234_5678; mem_req = 1'b1;
        #1;
        checks++;
        if (obs !== O_IDLE || jump_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs obs=%b addr=%h expected obs=%b addr=0", obs, jump_addr, O_IDLE);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; idle_inputs();
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL post_reset_idle obs=%b expected %b", obs, O_IDLE);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle_inputs(); set_hazard();
        #1;
        checks++;
        if (obs !== O_BUBBLE) begin
            errors++;
            $display("FAIL load_use_rs1 obs=%b expected %b", obs, O_BUBBLE);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL load_use_release obs=%b expected %b", obs, O_IDLE);
        end
        @(posedge clk);
        @(negedge clk);
        ex_is_load = 1'b1; ex_rd_addr = 5'd7; id_rs2_ren = 1'b1; id_rs2_addr = 5'd7;
        id_rs1_ren = 1'b1; id_rs1_addr = 5'd3;
        #1;
        checks++;
        if (obs !== O_BUBBLE) begin
            errors++;
            $display("FAIL load_use_rs2 obs=%b expected %b", obs, O_BUBBLE);
        end
        @(posedge clk);
        @(negedge clk);
        id_rs2_ren = 1'b0;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL match_without_ren obs=%b expected %b", obs, O_IDLE);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        ex_is_load = 1'b1; ex_rd_addr = 5'd0; id_rs1_ren = 1'b1; id_rs1_addr = 5'd0;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL load_use_x0 obs=%b expected %b", obs, O_IDLE);
        end
        @(posedge clk);
    endtask

    task automatic test_jump();
        @(negedge clk);
        idle_inputs(); set_hazard();
        ex_jump_en = 1'b1; ex_jump_addr = 32'h8000_0040;
        #1;
        checks++;
        if (obs !== O_JUMP || jump_addr !== 32'h8000_0040) begin
            errors++;
            $display("FAIL jump_over_hazard obs=%b addr=%h expected obs=%b addr=80000040", obs, jump_addr, O_JUMP);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (obs !== O_IDLE || jump_addr !== 32'h0) begin
            errors++;
            $display("FAIL jump_release obs=%b addr=%h expected obs=%b addr=0", obs, jump_addr, O_IDLE);
        end
        @(posedge clk);
    endtask

    task automatic test_mem_wait();
        @(negedge clk);
        idle_inputs(); mem_req = 1'b1; ex_jump_en = 1'b1; ex_jump_addr = 32'hDEAD_BEEC;
        #1;
        checks++;
        if (obs !== O_HOLD) begin
            errors++;
            $display("FAIL memstall_over_jump obs=%b expected %b", obs, O_HOLD);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (obs !== O_HOLD) begin
                errors++;
                $display("FAIL mem_wait_hold_%0d obs=%b expected %b", i, obs, O_HOLD);
            end
        end
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        checks++;
        if (obs !== O_JUMP || jump_addr !== 32'hDEAD_BEEC) begin
            errors++;
            $display("FAIL ack_release_jump obs=%b addr=%h expected obs=%b addr=deadbeec", obs, jump_addr, O_JUMP);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs(); set_hazard();
        #1;
        checks++;
        if (obs !== O_BUBBLE) begin
            errors++;
            $display("FAIL back_in_run obs=%b expected %b", obs, O_BUBBLE);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs(); mem_req = 1'b1; mem_ack = 1'b1;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL req_ack_same_cycle obs=%b expected %b", obs, O_IDLE);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs(); set_hazard();
        #1;
        checks++;
        if (obs !== O_BUBBLE) begin
            errors++;
            $display("FAIL no_wait_after_fast_ack obs=%b expected %b", obs, O_BUBBLE);
        end
        @(posedge clk);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        idle_inputs(); mem_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_in_wait obs=%b expected %b", obs, O_IDLE);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt);
        end
`endif
        rst = 1'b1; idle_inputs(); mem_ack = 1'b1;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL stale_ack_ignored obs=%b expected %b", obs, O_IDLE);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs(); set_hazard();
        #1;
        checks++;
        if (obs !== O_BUBBLE) begin
            errors++;
            $display("FAIL run_after_reset obs=%b expected %b", obs, O_BUBBLE);
        end
        @(posedge clk);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        idle_inputs(); mem_req = 1'b1;
        #1;
        checks++;
        if (obs !== O_HOLD) begin
            errors++;
            $display("FAIL timeout_stall obs=%b expected %b", obs, O_HOLD);
        end
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (obs !== O_HOLD) begin
                errors++;
                $display("FAIL wait_cycle_%0d obs=%b expected %b", i, obs, O_HOLD);
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (obs !== O_FAULT) begin
            errors++;
            $display("FAIL fault_entry obs=%b expected %b", obs, O_FAULT);
        end
        mem_req = 1'b0; mem_ack = 1'b1; ex_jump_en = 1'b1; ex_jump_addr = 32'h0000_0100;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (obs !== O_FAULT || jump_addr !== 32'h0) begin
            errors++;
            $display("FAIL fault_sticky obs=%b addr=%h expected obs=%b addr=0", obs, jump_addr, O_FAULT);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL fault_reset_low obs=%b expected %b", obs, O_IDLE);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; idle_inputs();
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL fault_cleared obs=%b expected %b", obs, O_IDLE);
        end
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_jump();
        test_mem_wait();
        test_reset_mid_wait();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
